inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction prefetch queue between instruction fetch and decode.
//  - Buffers fetched {pc, inst, adel} entries in a small circular FIFO.
//  - Hands the entries in order to the decode stage, which holds the main decoder.
//  - Decouples I-fetch timing from decode stalls; absorbs flushes on exception, ERET or redirect.
//  - Bubbles reach decode as a NOP (inst=0), so the decoder never flags them invalid.
// PARAMETERS
//  DEPTH  4  entry count; power of two, >=2
//  CW     $clog2(DEPTH+1)  width of the occupancy counter
// PORTS
//  clk       in   1   clock, rising edge
//  resetn    in   1   asynchronous, active-low reset
//  flush     in   1   discard all entries (exception/ERET/redirect)
//  if_valid  in   1   fetch offers an entry
//  if_pc     in   32  fetch PC
//  if_inst   in   32  fetched instruction word
//  if_adel   in   1   fetch address error on this PC
//  if_ready  out  1   queue accepts an entry this cycle
//  id_valid  out  1   head entry presented to decode
//  id_pc     out  32  head PC
//  id_inst   out  32  head instruction; 0 when id_valid=0
//  id_adel   out  1   head address-error tag
//  id_ready  in   1   decode consumes head this cycle (not stalled)
//  count     out  CW  current occupancy
// BEHAVIOUR
//  - Reset (resetn=0, async): head=tail=0, count=0, id_valid=0, id_pc=0, id_inst=0, id_adel=0, if_ready=1.
//  - push = if_valid & if_ready; pop = id_valid & id_ready; all state updates on posedge clk.
//  - if_ready = (count != DEPTH). It does not depend on id_ready, so there is no comb path from id_ready to if_ready.
//  - Storage: mem[tail] <= entry on push, tail+1; head+1 on pop. Both pointers wrap modulo DEPTH.
//  - count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
//  - id_valid = (count != 0). id_* are read combinationally from mem[head].
//  - Push into empty: latency 1 cycle (visible the cycle after the push edge).
//  - Full + pop same cycle: the push is still refused (if_ready=0). This gives 1 free slot next cycle.
//  - Empty + push + pop: no pop (id_valid=0). The entry is stored normally.
//  - if_adel=1: inst field stored as 32'h0; pc and adel are stored as given.
//  - id_inst/id_pc/id_adel forced to 0 whenever id_valid=0.
//  - flush=1: next edge head=tail=count=0. flush beats push and pop in the same cycle: no push written, no pop counted.
//  - Output ports are 0 from the cycle after flush.
//  - Order is strictly FIFO. No entry is duplicated or lost except by flush or reset.
//  - Reset asserted mid-operation drops all entries immediately (async); no partial state survives.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//  - When count==0, if_valid=1 and flush=0: id_valid=1 and id_* = if_* in the same cycle (0-cycle latency).
//  - If id_ready=1 as well, the entry is consumed and not written (count stays 0).
//  - If id_ready=0, the entry is written normally.
//  - Adds a combinational path if_* -> id_*.
//  IFQ_BYPASS_EN undefined:
//  - No bypass; push-to-visible latency is always 1 cycle.
//  - id_* depend only on registered state.
// TESTING
//  1 reset: resetn=0 mid-traffic -> same cycle: id_valid=0, count=0, if_ready=1, id_inst=0.
//  2 fill: id_ready=0, push pc 0xBFC00000/04/08/0C -> count=4, if_ready=0, 5th offer ignored.
//    Then id_ready=1 -> pcs pop in order, 1 per cycle.
//  3 simultaneous: count=2, push+pop each cycle for 10 cycles -> count stays 2.
//    Order preserved across pointer wrap.
//  4 flush: count=3, flush=1 with if_valid=1 -> next cycle count=0, id_valid=0, pushed entry never appears.
//  5 adel: push pc=0xBFC00001, adel=1, inst=0x8C010000 -> pops id_adel=1, id_inst=0, id_pc=0xBFC00001.
//  6 bypass: empty queue, push with id_ready=1.
//    - IFQ_BYPASS_EN defined: id_valid=1 in the same cycle, count stays 0.
//    - Undefined: id_valid=1 only in the next cycle.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : inst_fetch_queue                                               |
// | Brief    : Circular prefetch FIFO of {pc, inst, adel} between I-fetch and  |
// |            decode. Optional same-cycle bypass when IFQ_BYPASS_EN defined.  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_inst,
  input  logic          if_adel,
  output logic          if_ready,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  output logic          id_adel,
  input  logic          id_ready,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic          r_mem_adel [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_if_inst;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // A faulting fetch carries no usable word; decode sees a NOP with the adel tag.
  assign w_if_inst = if_adel ? 32'h0 : if_inst;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty & if_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry that decode takes immediately never occupies a slot.
  assign w_push = if_valid & ~w_full & ~flush & ~(w_bypass & id_ready);
  assign w_pop  = ~w_empty & id_ready & ~flush;

  assign if_ready = ~w_full;
  assign id_valid = ~w_empty | w_bypass;
  assign count    = r_count;

  always_comb begin
    id_pc   = 32'h0;
    id_inst = 32'h0;
    id_adel = 1'b0;
    if (!w_empty) begin
      id_pc   = r_mem_pc[r_head];
      id_inst = r_mem_inst[r_head];
      id_adel = r_mem_adel[r_head];
    end else if (w_bypass) begin
      id_pc   = if_pc;
      id_inst = w_if_inst;
      id_adel = if_adel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]   <= if_pc;
      r_mem_inst[r_tail] <= w_if_inst;
      r_mem_adel[r_tail] <= if_adel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_inst_fetch_queue                                            |
// | Brief    : Self-checking bench for inst_fetch_queue against a queue model. |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          if_adel;
  logic          if_ready;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          id_adel;
  logic          id_ready;
  logic [CW-1:0] count;

  ent_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel),
    .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel),
    .id_ready(id_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic adel, input logic rdy, input logic fl);
    if_valid = v; if_pc = pc; if_inst = inst; if_adel = adel;
    id_ready = rdy; flush = fl;
  endtask

  // One clock: the model advances on the edge using the inputs held over the cycle.
  task automatic cyc();
    int  n;
    bit  byp, pop, push;
    ent_t e;
    @(posedge clk);
    n = q.size();
    if (!resetn || flush) begin
      q.delete();
    end else begin
      byp  = BYP && n == 0 && if_valid;
      pop  = n != 0 && id_ready;
      push = if_valid && n != DEPTH && !(byp && id_ready);
      e.pc = if_pc; e.inst = if_adel ? 32'h0 : if_inst; e.adel = if_adel;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic model_out(output logic v, output logic [31:0] pc, output logic [31:0] inst,
                           output logic adel);
    v = 1'b0; pc = 32'h0; inst = 32'h0; adel = 1'b0;
    if (q.size() != 0) begin
      v = 1'b1; pc = q[0].pc; inst = q[0].inst; adel = q[0].adel;
    end else if (BYP && if_valid && !flush) begin
      v = 1'b1; pc = if_pc; inst = if_adel ? 32'h0 : if_inst; adel = if_adel;
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    #1;
    n_total++;
    if (id_valid !== 1'b0 || count !== '0 || if_ready !== 1'b1 || id_pc !== 32'h0 ||
        id_inst !== 32'h0 || id_adel !== 1'b0)
      $display("FAIL reset_init: got v=%b cnt=%0d rdy=%b pc=%h inst=%h adel=%b, want v=0 cnt=0 rdy=1 all 0",
               id_valid, count, if_ready, id_pc, id_inst, id_adel);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h1000 + 4 * i, $urandom, 0, 0, 0);
      cyc();
    end
    drive(1, 32'h2000, 32'h1234, 0, 0, 0);
    n_total++;
    if (count !== CW'(3)) $display("FAIL reset_pre_fill: got cnt=%0d, want 3", count);
    else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_total++;
    if (id_valid !== 1'b0 || count !== '0 || if_ready !== 1'b1 || id_inst !== 32'h0)
      $display("FAIL reset_async: got v=%b cnt=%0d rdy=%b inst=%h, want v=0 cnt=0 rdy=1 inst=0",
               id_valid, count, if_ready, id_inst);
    else n_pass++;
    cyc();
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fill();
    drive(0, 0, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hBFC00000 + 4 * i, $urandom, 0, 0, 0);
      cyc();
    end
    drive(1, 32'hBFC00010, 32'h5555, 0, 0, 0);
    #1;
    n_total++;
    if (count !== CW'(4) || if_ready !== 1'b0)
      $display("FAIL fill_full: got cnt=%0d rdy=%b, want cnt=4 rdy=0", count, if_ready);
    else n_pass++;
    cyc();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    n_total++;
    if (count !== CW'(4)) $display("FAIL fill_fifth_ignored: got cnt=%0d, want 4", count);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (id_valid !== 1'b1 || id_pc !== 32'hBFC00000 + 4 * i)
        $display("FAIL fill_pop_order: got v=%b pc=%h, want v=1 pc=%h", id_valid, id_pc,
                 32'hBFC00000 + 4 * i);
      else n_pass++;
      cyc();
    end
    #1;
    n_total++;
    if (count !== '0 || id_valid !== 1'b0 || id_pc !== 32'h0)
      $display("FAIL fill_drained: got cnt=%0d v=%b pc=%h, want 0 0 0", count, id_valid, id_pc);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h3000 + 4 * i, $urandom, 0, 0, 0);
      cyc();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h3000 + 4 * (k + 2), $urandom, 0, 1, 0);
      #1;
      n_total++;
      if (count !== CW'(2) || id_valid !== 1'b1 || id_pc !== 32'h3000 + 4 * k)
        $display("FAIL simul_push_pop: got cnt=%0d v=%b pc=%h, want cnt=2 v=1 pc=%h",
                 count, id_valid, id_pc, 32'h3000 + 4 * k);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h4000 + 4 * i, $urandom, 0, 0, 0);
      cyc();
    end
    drive(1, 32'hDEAD0000, 32'hFFFFFFFF, 0, 1, 1);
    cyc();
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (count !== '0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || if_ready !== 1'b1)
        $display("FAIL flush_empty: got cnt=%0d v=%b pc=%h inst=%h rdy=%b, want 0 0 0 0 1",
                 count, id_valid, id_pc, id_inst, if_ready);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_adel();
    drive(1, 32'hBFC00001, 32'h8C010000, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    n_total++;
    if (id_valid !== 1'b1 || id_adel !== 1'b1 || id_inst !== 32'h0 || id_pc !== 32'hBFC00001)
      $display("FAIL adel_entry: got v=%b adel=%b inst=%h pc=%h, want 1 1 00000000 bfc00001",
               id_valid, id_adel, id_inst, id_pc);
    else n_pass++;
    cyc();
  endtask

  task automatic test_bypass();
    drive(0, 0, 0, 0, 1, 1); cyc();
    drive(1, 32'h5000, 32'h24010001, 0, 1, 0);
    #1;
    n_total++;
    if (id_valid !== BYP || id_pc !== (BYP ? 32'h5000 : 32'h0))
      $display("FAIL bypass_same_cycle: got v=%b pc=%h, want v=%b pc=%h", id_valid, id_pc,
               BYP, BYP ? 32'h5000 : 32'h0);
    else n_pass++;
    cyc();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    n_total++;
    if (BYP ? (id_valid !== 1'b0 || count !== '0)
            : (id_valid !== 1'b1 || count !== CW'(1) || id_pc !== 32'h5000 || id_inst !== 32'h24010001))
      $display("FAIL bypass_next_cycle: got v=%b cnt=%0d pc=%h inst=%h (bypass=%b)",
               id_valid, count, id_pc, id_inst, BYP);
    else n_pass++;
    cyc();
  endtask

  task automatic test_random();
    logic        ev, eadel;
    logic [31:0] epc, einst;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) < 5, $urandom_range(0, 24) == 0);
      #1;
      model_out(ev, epc, einst, eadel);
      n_total++;
      if (id_valid !== ev || id_pc !== epc || id_inst !== einst || id_adel !== eadel ||
          count !== CW'(q.size()) || if_ready !== (q.size() != DEPTH))
        $display("FAIL random_c%0d: got v=%b pc=%h inst=%h adel=%b cnt=%0d rdy=%b, want v=%b pc=%h inst=%h adel=%b cnt=%0d rdy=%b",
                 c, id_valid, id_pc, id_inst, id_adel, count, if_ready,
                 ev, epc, einst, eadel, q.size(), q.size() != DEPTH);
      else n_pass++;
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_simultaneous();
    test_flush();
    test_adel();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
